// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-memory request sequencer, beq resolution and MEM/WB fill.
// Memory ops hold the front end in WAIT until dmem_ack; a missing ack latches a sticky error.
module ex_mem_stage #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_W    = 5,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [2:0]        ex_M,
   input  logic [1:0]        ex_WB,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic              ex_zero,
   input  logic [DATA_W-1:0] ex_write_data,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic [DATA_W-1:0] ex_branch_target,
   input  logic              flush,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              mem_stall,
   output logic              pc_src,
   output logic [DATA_W-1:0] branch_target,
   output logic              wb_valid,
   output logic [1:0]        wb_WB,
   output logic [DATA_W-1:0] wb_read_data,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [REG_W-1:0]  wb_rd,
   output logic              mem_err
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {StIdle, StWait, StErr} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flush_pend_q;

   logic               em_valid_q;
   logic [2:0]         em_m_q;
   logic [1:0]         em_wb_q;
   logic [DATA_W-1:0]  em_alu_q;
   logic               em_zero_q;
   logic [DATA_W-1:0]  em_wdata_q;
   logic [REG_W-1:0]   em_rd_q;
   logic [DATA_W-1:0]  em_target_q;

   logic               wb_valid_q;
   logic [1:0]         wb_wb_q;
   logic [DATA_W-1:0]  wb_rdata_q;
   logic [DATA_W-1:0]  wb_alu_q;
   logic [REG_W-1:0]   wb_rd_q;

   logic               capture;
   logic               cap_valid;
   logic               cap_mem;
   logic               wb_load;
   logic               wb_bubble;
   logic               em_is_load;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dmem_req   = (state_q == StWait);
      mem_stall  = (state_q == StErr) | ((state_q == StWait) & ~dmem_ack);
      capture    = ~mem_stall;
      cap_valid  = ex_valid & ~(flush | flush_pend_q);
      cap_mem    = cap_valid & (ex_M[1] | ex_M[2]);
      wb_load    = (state_q == StIdle) | ((state_q == StWait) & dmem_ack);
      wb_bubble  = (state_q == StWait) & ~dmem_ack;
      // Both MemRead and MemWrite set is a store, so only a pure read returns data
      em_is_load = em_m_q[1] & ~em_m_q[2];
      unique case (state_q)
         StIdle: begin
            state_d = cap_mem ? StWait : StIdle;
            cnt_d   = '0;
         end
         StWait: begin
            if (dmem_ack) begin
               state_d = cap_mem ? StWait : StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MAX_WAIT - 1)) state_d = StErr;
            end
         end
         StErr:   state_d = StErr;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture)    flush_pend_q <= 1'b0;
         else if (flush) flush_pend_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         em_valid_q  <= 1'b0;
         em_m_q      <= '0;
         em_wb_q     <= '0;
         em_alu_q    <= '0;
         em_zero_q   <= 1'b0;
         em_wdata_q  <= '0;
         em_rd_q     <= '0;
         em_target_q <= '0;
      end else if (capture) begin
         em_valid_q  <= cap_valid;
         em_m_q      <= ex_M;
         em_wb_q     <= ex_WB;
         em_alu_q    <= ex_alu_result;
         em_zero_q   <= ex_zero;
         em_wdata_q  <= ex_write_data;
         em_rd_q     <= ex_rd;
         em_target_q <= ex_branch_target;
      end
   end

   // ERR freezes MEM/WB; the timing-out WAIT edge has already left a bubble there
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_wb_q    <= '0;
         wb_rdata_q <= '0;
         wb_alu_q   <= '0;
         wb_rd_q    <= '0;
      end else if (wb_load) begin
         wb_valid_q <= em_valid_q;
         wb_wb_q    <= em_wb_q;
         wb_rdata_q <= ((state_q == StWait) && em_is_load) ? dmem_rdata : '0;
         wb_alu_q   <= em_alu_q;
         wb_rd_q    <= em_rd_q;
      end else if (wb_bubble) begin
         wb_valid_q <= 1'b0;
      end
   end

   assign dmem_we       = em_m_q[2];
   assign dmem_addr     = em_alu_q;
   assign dmem_wdata    = em_wdata_q;
   assign pc_src        = em_valid_q & em_m_q[0] & em_zero_q;
   assign branch_target = em_target_q;
   assign mem_err       = (state_q == StErr);
   assign wb_valid      = wb_valid_q;
   assign wb_WB         = wb_wb_q;
   assign wb_read_data  = wb_rdata_q;
   assign wb_alu_result = wb_alu_q;
   assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scenario bench for ex_mem_stage: MEM/WB contents are scoreboarded in issue order,
// handshake, stall, branch and error timing are checked inline per scenario.
module tb_ex_mem_stage;

   localparam int unsigned MAXW = 15;

   logic        clk;
   logic        rst;
   logic        ex_valid;
   logic [2:0]  ex_M;
   logic [1:0]  ex_WB;
   logic [31:0] ex_alu_result;
   logic        ex_zero;
   logic [31:0] ex_write_data;
   logic [4:0]  ex_rd;
   logic [31:0] ex_branch_target;
   logic        flush;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        mem_stall;
   logic        pc_src;
   logic [31:0] branch_target;
   logic        wb_valid;
   logic [1:0]  wb_WB;
   logic [31:0] wb_read_data;
   logic [31:0] wb_alu_result;
   logic [4:0]  wb_rd;
   logic        mem_err;

   typedef struct {
      logic [1:0]  wb;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors;
   int   miscompares;

   ex_mem_stage #(.DATA_W(32), .REG_W(5), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_M(ex_M), .ex_WB(ex_WB),
      .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_write_data(ex_write_data),
      .ex_rd(ex_rd), .ex_branch_target(ex_branch_target), .flush(flush),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(branch_target),
      .wb_valid(wb_valid), .wb_WB(wb_WB), .wb_read_data(wb_read_data),
      .wb_alu_result(wb_alu_result), .wb_rd(wb_rd), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every retired MEM/WB entry must match the oldest expected one
   always @(posedge clk) begin
      #1;
      if (wb_valid === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL wb_unexpected: wb_valid=1 rd=%0d alu=%h, nothing expected",
                     wb_rd, wb_alu_result);
         end else begin
            mon_e = sb.pop_front();
            if ({wb_WB, wb_alu_result, wb_rd, wb_read_data} !==
                {mon_e.wb, mon_e.alu, mon_e.rd, mon_e.rdata}) begin
               miscompares++;
               $display("FAIL wb_entry: got wb=%b alu=%h rd=%0d rdata=%h want wb=%b alu=%h rd=%0d rdata=%h",
                        wb_WB, wb_alu_result, wb_rd, wb_read_data,
                        mon_e.wb, mon_e.alu, mon_e.rd, mon_e.rdata);
            end
         end
      end
   end

   task automatic set_ex(input logic v, input logic [2:0] m, input logic [1:0] wb,
                         input logic [31:0] alu, input logic z, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] tgt);
      ex_valid = v; ex_M = m; ex_WB = wb; ex_alu_result = alu; ex_zero = z;
      ex_write_data = wd; ex_rd = rd; ex_branch_target = tgt;
   endtask

   task automatic clr_ex();
      set_ex(1'b0, 3'b000, 2'b00, 32'h0, 1'b0, 32'h0, 5'd0, 32'h0);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      clr_ex();
      repeat (2) @(negedge clk);
      vectors++;
      if ({dmem_req, dmem_we, mem_stall, pc_src, wb_valid, mem_err} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {dmem_req, dmem_we, mem_stall, pc_src, wb_valid, mem_err});
      end
      vectors++;
      if ({wb_WB, wb_read_data, wb_alu_result, wb_rd} !== '0) begin
         miscompares++;
         $display("FAIL reset_wb: got wb=%b rdata=%h alu=%h rd=%0d want all 0",
                  wb_WB, wb_read_data, wb_alu_result, wb_rd);
      end
      vectors++;
      if ({dmem_addr, dmem_wdata, branch_target} !== '0) begin
         miscompares++;
         $display("FAIL reset_regs: got addr=%h wdata=%h tgt=%h want 0",
                  dmem_addr, dmem_wdata, branch_target);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      logic stall_seen;
      stall_seen = 1'b0;
      @(negedge clk);
      set_ex(1'b1, 3'b000, 2'b10, 32'h1234, 1'b0, 32'h0, 5'd8, 32'h0);
      sb.push_back('{2'b10, 32'h1234, 5'd8, 32'h0});
      #1 stall_seen |= mem_stall;
      @(negedge clk);
      clr_ex();
      #1 stall_seen |= mem_stall;
      vectors++;
      if (wb_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL alu_latency: wb_valid=%b one cycle after capture, want 0", wb_valid);
      end
      @(negedge clk);
      stall_seen |= mem_stall;
      vectors++;
      if (wb_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL alu_wb_valid: got %b want 1", wb_valid);
      end
      vectors++;
      if (stall_seen !== 1'b0) begin
         miscompares++;
         $display("FAIL alu_no_stall: mem_stall seen=%b want 0", stall_seen);
      end
   endtask

   task automatic test_load();
      int req_n, stall_n, bub_n;
      req_n = 0; stall_n = 0; bub_n = 0;
      @(negedge clk);
      set_ex(1'b1, 3'b010, 2'b11, 32'h40, 1'b0, 32'h0, 5'd5, 32'h0);
      sb.push_back('{2'b11, 32'h40, 5'd5, 32'hDEADBEEF});
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         clr_ex();
         if (c == 3) begin
            dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
         end
         #1;
         if (dmem_req === 1'b1) req_n++;
         if (mem_stall === 1'b1) stall_n++;
         if (c > 1 && wb_valid === 1'b0) bub_n++;
         if (c == 1) begin
            vectors++;
            if ({dmem_we, dmem_addr} !== {1'b0, 32'h40}) begin
               miscompares++;
               $display("FAIL lw_request: got we=%b addr=%h want we=0 addr=00000040",
                        dmem_we, dmem_addr);
            end
         end
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      vectors++;
      if ({req_n, stall_n, bub_n} !== {32'd3, 32'd2, 32'd2}) begin
         miscompares++;
         $display("FAIL lw_timing: got req=%0d stall=%0d bubbles=%0d want 3 2 2",
                  req_n, stall_n, bub_n);
      end
      vectors++;
      if ({wb_valid, dmem_req, mem_stall} !== 3'b100) begin
         miscompares++;
         $display("FAIL lw_done: got valid/req/stall=%b want 100",
                  {wb_valid, dmem_req, mem_stall});
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_ex(1'b1, 3'b100, 2'b00, 32'h80, 1'b0, 32'hCAFEF00D, 5'd0, 32'h0);
      sb.push_back('{2'b00, 32'h80, 5'd0, 32'h0});
      @(negedge clk);
      set_ex(1'b1, 3'b010, 2'b11, 32'h44, 1'b0, 32'h0, 5'd9, 32'h0);
      sb.push_back('{2'b11, 32'h44, 5'd9, 32'h11223344});
      dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
      #1;
      vectors++;
      if ({dmem_req, dmem_we, mem_stall} !== 3'b110) begin
         miscompares++;
         $display("FAIL sw_ctrl: got req/we/stall=%b want 110", {dmem_req, dmem_we, mem_stall});
      end
      vectors++;
      if ({dmem_addr, dmem_wdata} !== {32'h80, 32'hCAFEF00D}) begin
         miscompares++;
         $display("FAIL sw_data: got addr=%h wdata=%h want 00000080 cafef00d",
                  dmem_addr, dmem_wdata);
      end
      @(negedge clk);
      clr_ex();
      dmem_rdata = 32'h11223344;
      #1;
      vectors++;
      if ({dmem_req, dmem_we, mem_stall, wb_valid} !== 4'b1001 || dmem_addr !== 32'h44) begin
         miscompares++;
         $display("FAIL b2b_lw: got req/we/stall/wbv=%b addr=%h want 1001 00000044",
                  {dmem_req, dmem_we, mem_stall, wb_valid}, dmem_addr);
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      vectors++;
      if ({dmem_req, wb_valid} !== 2'b01) begin
         miscompares++;
         $display("FAIL b2b_done: got req/wbv=%b want 01", {dmem_req, wb_valid});
      end
   endtask

   task automatic test_branch_flush();
      int pc_n;
      pc_n = 0;
      @(negedge clk);
      set_ex(1'b1, 3'b001, 2'b00, 32'h0, 1'b1, 32'h0, 5'd0, 32'h100);
      sb.push_back('{2'b00, 32'h0, 5'd0, 32'h0});
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         clr_ex();
         #1;
         if (pc_src === 1'b1) begin
            pc_n++;
            vectors++;
            if (branch_target !== 32'h100) begin
               miscompares++;
               $display("FAIL beq_target: got %h want 00000100", branch_target);
            end
         end
      end
      vectors++;
      if (pc_n != 1) begin
         miscompares++;
         $display("FAIL beq_pulse: pc_src high %0d cycles want 1", pc_n);
      end
      // Flush arrives while the lw stalls; the squashed load must never reach memory
      @(negedge clk);
      set_ex(1'b1, 3'b010, 2'b11, 32'h48, 1'b0, 32'h0, 5'd3, 32'h0);
      sb.push_back('{2'b11, 32'h48, 5'd3, 32'hA5A5A5A5});
      @(negedge clk);
      set_ex(1'b1, 3'b010, 2'b11, 32'h777, 1'b0, 32'h0, 5'd7, 32'h0);
      flush = 1'b1;
      #1;
      vectors++;
      if (mem_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_stall: got mem_stall=%b want 1", mem_stall);
      end
      @(negedge clk);
      flush = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      clr_ex();
      #1;
      vectors++;
      if ({wb_valid, dmem_req, mem_stall, pc_src} !== 4'b1000) begin
         miscompares++;
         $display("FAIL flush_deferred: got wbv/req/stall/pc=%b want 1000",
                  {wb_valid, dmem_req, mem_stall, pc_src});
      end
      @(negedge clk);
      vectors++;
      if (wb_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_squash: got wb_valid=%b want 0", wb_valid);
      end
   endtask

   task automatic test_timeout();
      int  req_n;
      bit  done;
      req_n = 0; done = 1'b0;
      @(negedge clk);
      set_ex(1'b1, 3'b010, 2'b11, 32'h50, 1'b0, 32'h0, 5'd4, 32'h0);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         clr_ex();
         if (mem_err === 1'b1) done = 1'b1;
         else if (dmem_req === 1'b1) req_n++;
      end
      vectors++;
      if (!done || req_n != int'(MAXW)) begin
         miscompares++;
         $display("FAIL timeout: reached=%0d wait_cycles=%0d want 1 %0d", done, req_n, MAXW);
      end
      vectors++;
      if ({dmem_req, mem_stall, mem_err} !== 3'b011) begin
         miscompares++;
         $display("FAIL err_outputs: got req/stall/err=%b want 011",
                  {dmem_req, mem_stall, mem_err});
      end
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'hBAD;
      #1;
      vectors++;
      if ({dmem_req, mem_stall, mem_err} !== 3'b011) begin
         miscompares++;
         $display("FAIL err_late_ack: got req/stall/err=%b want 011",
                  {dmem_req, mem_stall, mem_err});
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      vectors++;
      if ({mem_err, wb_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL err_hold: got err/wbv=%b want 10", {mem_err, wb_valid});
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({mem_err, mem_stall, dmem_req} !== 3'b000) begin
         miscompares++;
         $display("FAIL err_reset: got err/stall/req=%b want 000", {mem_err, mem_stall, dmem_req});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      set_ex(1'b1, 3'b000, 2'b10, 32'h99, 1'b0, 32'h0, 5'd6, 32'h0);
      sb.push_back('{2'b10, 32'h99, 5'd6, 32'h0});
      @(negedge clk);
      set_ex(1'b1, 3'b010, 2'b11, 32'h60, 1'b0, 32'h0, 5'd2, 32'h0);
      @(negedge clk);
      clr_ex();
      #1;
      vectors++;
      if ({dmem_req, mem_stall, wb_valid} !== 3'b111) begin
         miscompares++;
         $display("FAIL pre_reset: got req/stall/wbv=%b want 111", {dmem_req, mem_stall, wb_valid});
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({dmem_req, mem_stall, wb_valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL async_rst_ctrl: got req/stall/wbv=%b want 000",
                  {dmem_req, mem_stall, wb_valid});
      end
      vectors++;
      if ({wb_WB, wb_alu_result, wb_rd, wb_read_data} !== '0) begin
         miscompares++;
         $display("FAIL async_rst_wb: got wb=%b alu=%h rd=%0d rdata=%h want 0",
                  wb_WB, wb_alu_result, wb_rd, wb_read_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({dmem_req, wb_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL post_reset: got req/wbv=%b want 00", {dmem_req, wb_valid});
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_alu();
      test_load();
      test_back_to_back();
      test_branch_flush();
      test_timeout();
      test_async_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL sb_drain: %0d expected entries never retired", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register plus memory-access sequencer for the 5-stage pipeline.
- Captures EX results and the 3-bit M control bundle: M[0]=Branch, M[1]=MemRead, M[2]=MemWrite.
- Drives the data-memory request/ack handshake, stalls the front end while an access is outstanding, resolves beq, and fills the MEM/WB register.
- Sits between the EX stage and the write-back stage.

Parameters:
- DATA_W, 32, datapath and address width.
- REG_W, 5, destination register index width.
- MAX_WAIT, 15, WAIT cycles without dmem_ack before a memory timeout is declared.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_M  in  3  {MemWrite, MemRead, Branch}.
- ex_WB  in  2  {RegWrite, MemtoReg}.
- ex_alu_result  in  DATA_W  ALU result / memory address.
- ex_zero  in  1  ALU zero flag.
- ex_write_data  in  DATA_W  store data (rt).
- ex_rd  in  REG_W  destination register.
- ex_branch_target  in  DATA_W  computed branch target.
- flush  in  1  squash the instruction currently in EX.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DATA_W  access address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  memory completed the request this cycle.
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack.
- mem_stall  out  1  freeze PC, IF/ID and ID/EX.
- pc_src  out  1  take branch.
- branch_target  out  DATA_W  PC target when pc_src=1.
- wb_valid  out  1  MEM/WB holds a real instruction.
- wb_WB  out  2  WB control bits.
- wb_read_data  out  DATA_W  loaded data.
- wb_alu_result  out  DATA_W  forwarded ALU result.
- wb_rd  out  REG_W  destination register.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, rst=1): every register and output goes to 0, FSM goes to IDLE, wait counter=0, pending-flush flag=0. Reset mid-access drops dmem_req immediately; no MEM/WB update occurs.
- FSM states: IDLE, WAIT, ERR.
- Capture: on each edge where mem_stall=0, EX/MEM loads all ex_* fields. The captured valid is ex_valid & ~(flush | flush_pending); flush_pending clears on that edge.
- Flush while mem_stall=1 sets flush_pending, which is applied at the next capture edge. The in-flight EX/MEM entry is never squashed.
- IDLE, captured entry valid with MemRead or MemWrite: next state is WAIT on the same capture edge, and the counter clears.
- IDLE, non-memory entry: moves to MEM/WB on the next edge (1-cycle stage latency).
- WAIT: dmem_req=1; dmem_we=MemWrite; addr and wdata come from EX/MEM registers and are stable until ack.
  - mem_stall = ~dmem_ack.
  - On dmem_ack: MEM/WB loads the entry, with wb_read_data=dmem_rdata for a load and 0 for a store.
  - Same edge: FSM goes to IDLE and EX/MEM captures the next instruction. Back-to-back memory ops go WAIT to WAIT without an idle cycle.
- Stall bubbles: each edge in WAIT without ack writes wb_valid=0.
- Timeout: counter increments per WAIT cycle without ack. When counter reaches MAX_WAIT, next state is ERR.
- ERR: dmem_req=0, mem_stall=1, mem_err=1, all held until rst; dmem_ack is ignored.
- Branch: pc_src = valid & M[0] & zero, combinational from EX/MEM; branch_target comes from the EX/MEM register.
  - A branch entry never enters WAIT, so pc_src is high for exactly one cycle.
  - The hazard unit uses pc_src to assert flush.
- Illegal M with both MemRead and MemWrite set is treated as a store.
- dmem_req never asserts for an invalid (flushed) entry.

Test Plan:
- ALU op (WB=2'b10, result=0x1234, rd=8), no memory: next edge wb_valid=1, wb_alu_result=0x1234, wb_rd=8; mem_stall never asserted.
- lw addr=0x40, ack after 3 cycles with rdata=0xDEADBEEF: dmem_req high for 3 cycles, mem_stall high for 2, then wb_read_data=0xDEADBEEF, wb_valid=1; 2 bubble cycles (wb_valid=0) before it.
- sw with ack in the first WAIT cycle, followed immediately by lw: dmem_we=1 with wdata latched for one cycle, then dmem_req stays high with dmem_we=0; no idle gap.
- beq with zero=1, target=0x100: pc_src=1 for exactly one cycle with branch_target=0x100. Flush asserted during a later lw stall is deferred, and the next captured entry has valid=0.
- lw with no ack for MAX_WAIT cycles: ERR; mem_err=1, dmem_req=0, mem_stall=1 persists; a late ack has no effect; rst clears everything.
- rst pulse asynchronously mid-WAIT: dmem_req, mem_stall and all wb_* outputs go to 0 before the next edge.
